// File: rtl/dispatcher_pkg.sv
// Shared dispatcher definitions: table sizing defaults
// and the service-arbiter FSM state encoding.
package dispatcher_pkg;

  localparam int RES_ID_WIDTH         = 10;
  localparam int RES_TABLE_ADDR_WIDTH = 3;
  localparam int NUMBER_RES_TABLES    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OFFER   = 2'd3
  } svc_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: rotate requests so rr_ptr is bit 0,
// take the lowest set bit, rotate the result back.
module rr_priority_picker
  import dispatcher_pkg::*;
#(
  parameter int N  = NUMBER_RES_TABLES,
  parameter int AW = RES_TABLE_ADDR_WIDTH
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [AW-1:0] index,
  output logic          any
);

  logic [N-1:0]  rot;
  logic [AW-1:0] off;

  // rotate so the search starts at ptr; N == 2**AW so the add wraps
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[ptr + AW'(i)];
    end
  end

  // lowest set bit of the rotated vector wins
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = AW'(i);
    end
  end

  assign any   = |req;
  assign index = ptr + off;
  assign grant = any ? (N'(1) << index) : '0;

endmodule

// File: rtl/resource_table_service_arbiter.sv
// Round-robin service scheduler for the resource-update
// buffer's shared output mux; hands results to the allocator.
module resource_table_service_arbiter
  import dispatcher_pkg::*;
#(
  parameter int RES_ID_WIDTH_P         = RES_ID_WIDTH,
  parameter int RES_TABLE_ADDR_WIDTH_P = RES_TABLE_ADDR_WIDTH,
  parameter int NUMBER_RES_TABLES_P    = NUMBER_RES_TABLES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUMBER_RES_TABLES_P-1:0]    res_table_waiting,
  output logic [NUMBER_RES_TABLES_P-1:0]    serviced_table,
  input  logic [RES_ID_WIDTH_P:0]           buf_size,
  input  logic [RES_ID_WIDTH_P-1:0]         buf_addr,
  input  logic                              svc_enable,
  output logic                              svc_valid,
  input  logic                              svc_ready,
  output logic [RES_TABLE_ADDR_WIDTH_P-1:0] svc_table_id,
  output logic [RES_ID_WIDTH_P:0]           svc_size,
  output logic [RES_ID_WIDTH_P-1:0]         svc_addr,
  output logic                              svc_busy
);

  localparam int N  = NUMBER_RES_TABLES_P;
  localparam int AW = RES_TABLE_ADDR_WIDTH_P;

  svc_state_t    state;
  logic [AW-1:0] rr_ptr;
  logic [N-1:0]  pick_grant;
  logic [AW-1:0] pick_index;
  logic          pick_any;

  rr_priority_picker #(
    .N  (N),
    .AW (AW)
  ) u_picker (
    .req   (res_table_waiting),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .index (pick_index),
    .any   (pick_any)
  );

  // service FSM; every output is a register so the strobe
  // and the allocator handshake are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      serviced_table <= '0;
      svc_valid      <= 1'b0;
      svc_table_id   <= '0;
      svc_size       <= '0;
      svc_addr       <= '0;
      svc_busy       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (svc_enable && pick_any) begin
            serviced_table <= pick_grant;
            svc_table_id   <= pick_index;
            svc_busy       <= 1'b1;
            state          <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          serviced_table <= '0;
          rr_ptr         <= svc_table_id + 1'b1;
          state          <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          svc_size  <= buf_size;
          svc_addr  <= buf_addr;
          svc_valid <= 1'b1;
          state     <= ST_OFFER;
        end
        ST_OFFER: begin
          if (svc_ready) begin
            svc_valid <= 1'b0;
            svc_busy  <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resource_table_service_arbiter.sv
// Directed bench for the table service arbiter:
// reset, single service, fairness, wrap, backpressure, enable.
module tb_resource_table_service_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  res_table_waiting;
  logic [7:0]  serviced_table;
  logic [10:0] buf_size;
  logic [9:0]  buf_addr;
  logic        svc_enable;
  logic        svc_valid;
  logic        svc_ready;
  logic [2:0]  svc_table_id;
  logic [10:0] svc_size;
  logic [9:0]  svc_addr;
  logic        svc_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  resource_table_service_arbiter dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .res_table_waiting (res_table_waiting),
    .serviced_table    (serviced_table),
    .buf_size          (buf_size),
    .buf_addr          (buf_addr),
    .svc_enable        (svc_enable),
    .svc_valid         (svc_valid),
    .svc_ready         (svc_ready),
    .svc_table_id      (svc_table_id),
    .svc_size          (svc_size),
    .svc_addr          (svc_addr),
    .svc_busy          (svc_busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full service from IDLE with ready high; ends in IDLE
  task automatic serve(input string tag,
                       input logic [7:0] w,
                       input logic [7:0] w_after,
                       input logic [7:0] exp_st,
                       input logic [2:0] exp_id,
                       input logic [10:0] sz,
                       input logic [9:0] ad);
    res_table_waiting = w;
    tick();
    check({tag, ".strobe"}, 32'(serviced_table), 32'(exp_st));
    check({tag, ".busy"}, 32'(svc_busy), 32'd1);
    res_table_waiting = w_after;
    buf_size = sz;
    buf_addr = ad;
    tick();
    check({tag, ".strobe_off"}, 32'(serviced_table), 32'd0);
    check({tag, ".early_valid"}, 32'(svc_valid), 32'd0);
    tick();
    buf_size = ~sz;
    buf_addr = ~ad;
    check({tag, ".valid"}, 32'(svc_valid), 32'd1);
    check({tag, ".id"}, 32'(svc_table_id), 32'(exp_id));
    check({tag, ".size"}, 32'(svc_size), 32'(sz));
    check({tag, ".addr"}, 32'(svc_addr), 32'(ad));
    check({tag, ".no_strobe"}, 32'(serviced_table), 32'd0);
    tick();
    check({tag, ".valid_drop"}, 32'(svc_valid), 32'd0);
    check({tag, ".idle"}, 32'(svc_busy), 32'd0);
  endtask

  initial begin
    rst_n             = 1'b0;
    res_table_waiting = '0;
    buf_size          = '0;
    buf_addr          = '0;
    svc_enable        = 1'b1;
    svc_ready         = 1'b1;
    #12;
    check("rst.strobe", 32'(serviced_table), 32'd0);
    check("rst.valid", 32'(svc_valid), 32'd0);
    check("rst.busy", 32'(svc_busy), 32'd0);
    check("rst.size", 32'(svc_size), 32'd0);
    rst_n = 1'b1;
    tick();

    // single request on table 2
    serve("single", 8'h04, 8'h00, 8'h04, 3'd2, 11'h0A5, 10'h3C1);
    tick();
    check("single.quiet", 32'(serviced_table), 32'd0);

    // reset mid-OFFER; table 0 served so ptr would become 1
    svc_ready = 1'b0;
    res_table_waiting = 8'h01;
    tick();
    check("rstmid.strobe", 32'(serviced_table), 32'h01);
    res_table_waiting = 8'h00;
    tick();
    tick();
    check("rstmid.valid", 32'(svc_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid.valid0", 32'(svc_valid), 32'd0);
    check("rstmid.strobe0", 32'(serviced_table), 32'd0);
    check("rstmid.busy0", 32'(svc_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    svc_ready = 1'b1;
    tick();
    check("rstmid.no_reissue", 32'(serviced_table), 32'd0);

    // fairness: all waiting, order 0..7,0 from a reset pointer
    for (int k = 0; k < 9; k++) begin
      serve("fair", 8'hFF, (k == 8) ? 8'h00 : 8'hFF,
            8'(1 << (k % 8)), 3'(k % 8),
            11'(k * 3 + 1), 10'(k * 5 + 2));
    end
    tick();
    check("fair.stop", 32'(serviced_table), 32'd0);

    // wrap: table 5 sets ptr=6, then 0x41 grants 6 then 0
    serve("wrap5", 8'h20, 8'h00, 8'h20, 3'd5, 11'h011, 10'h022);
    serve("wrap6", 8'h41, 8'h41, 8'h40, 3'd6, 11'h7FF, 10'h3FF);
    serve("wrap0", 8'h41, 8'h00, 8'h01, 3'd0, 11'h400, 10'h200);

    // backpressure: hold OFFER for 10 cycles with buf_* moving
    svc_ready = 1'b0;
    res_table_waiting = 8'h02;
    tick();
    check("bp.strobe", 32'(serviced_table), 32'h02);
    buf_size = 11'h155;
    buf_addr = 10'h2AA;
    tick();
    tick();
    for (int k = 0; k < 10; k++) begin
      buf_size = 11'($urandom);
      buf_addr = 10'($urandom);
      tick();
      check("bp.valid", 32'(svc_valid), 32'd1);
      check("bp.id", 32'(svc_table_id), 32'd1);
      check("bp.size", 32'(svc_size), 32'h155);
      check("bp.addr", 32'(svc_addr), 32'h2AA);
      check("bp.no_strobe", 32'(serviced_table), 32'd0);
    end
    res_table_waiting = 8'h00;
    svc_ready = 1'b1;
    tick();
    check("bp.done_valid", 32'(svc_valid), 32'd0);
    check("bp.done_busy", 32'(svc_busy), 32'd0);

    // enable low blocks new grants
    svc_enable = 1'b0;
    res_table_waiting = 8'h10;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en.blocked", 32'(serviced_table), 32'd0);
      check("en.idle", 32'(svc_busy), 32'd0);
    end
    svc_enable = 1'b1;
    tick();
    check("en.strobe", 32'(serviced_table), 32'h10);
    svc_enable = 1'b0;
    tick();
    tick();
    check("en.valid", 32'(svc_valid), 32'd1);
    check("en.id", 32'(svc_table_id), 32'd4);
    tick();
    check("en.done", 32'(svc_busy), 32'd0);
    tick();
    check("en.no_regrant", 32'(serviced_table), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
